// File: rtl/sha_pkg.sv
// ============================================================================
// sha_pkg : shared constants, block type and padder state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package sha_pkg;

    localparam int          SHA_BLK_BITS  = 512;
    localparam int          SHA_BLK_BYTES = 64;
    localparam int          SHA_LEN_OFS   = 56;
    localparam logic [7:0]  SHA_PAD_BYTE  = 8'h80;

    typedef logic [SHA_BLK_BITS-1:0] sha_blk_t;

    typedef enum logic [2:0] {
        ST_ABSORB    = 3'd0,
        ST_FULL      = 3'd1,
        ST_PAD1      = 3'd2,
        ST_PADA      = 3'd3,
        ST_PADB      = 3'd4,
        ST_PADZ      = 3'd5,
        ST_EMIT_MID  = 3'd6,
        ST_EMIT_LAST = 3'd7
    } pad_state_e;

endpackage

`default_nettype wire

// File: rtl/sha_pad_fill.sv
// ============================================================================
// sha_pad_fill : combinational padding of a partially filled block
// Rev 1.0
// ============================================================================
`default_nettype none

module sha_pad_fill
    import sha_pkg::*;
(
    input  sha_blk_t    blk_i,
    input  logic [6:0]  idx_i,
    input  logic [63:0] len_i,
    input  logic        put_len_i,
    input  logic        put_mark_i,
    output sha_blk_t    blk_o
);

    // Bytes below idx keep message data; byte idx takes the marker (or zero);
    // everything above is zero, and the last eight bytes optionally carry the length.
    always_comb begin
        blk_o = blk_i;
        for (int b = 0; b < SHA_BLK_BYTES; b++) begin
            if ((7'(b) == idx_i) && put_mark_i) begin
                blk_o[SHA_BLK_BITS-1-8*b -: 8] = SHA_PAD_BYTE;
            end else if (7'(b) >= idx_i) begin
                blk_o[SHA_BLK_BITS-1-8*b -: 8] = 8'h00;
            end
            if (put_len_i && (b >= SHA_LEN_OFS)) begin
                blk_o[SHA_BLK_BITS-1-8*b -: 8] = len_i[63-8*(b-SHA_LEN_OFS) -: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sha_msg_padder.sv
// ============================================================================
// sha_msg_padder : byte stream to padded 512-bit SHA-256 blocks
// Optional length check enabled by defining SHA_PAD_LEN_CHK_EN (adds len_err).
// Rev 1.0
// ============================================================================
`default_nettype none

module sha_msg_padder
    import sha_pkg::*;
#(
    parameter logic [63:0] MAX_MSG_BYTES = 64'hFFFF_FFFF,
    parameter int unsigned LEN_W         = 64
)(
    input  logic         clk_p,
    input  logic         rst_p,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic         in_null,
    output logic         in_rdy,
    output logic [511:0] msg_data,
    output logic         msg_valid,
    input  logic         msg_rdy,
    output logic         blk_first,
    output logic         blk_last
`ifdef SHA_PAD_LEN_CHK_EN
    ,
    output logic         len_err
`endif
);

    if ((LEN_W > 64) || (LEN_W < 4) || (MAX_MSG_BYTES == 64'd0)) begin : g_bad_cfg
        $error("sha_msg_padder: unsupported LEN_W or MAX_MSG_BYTES");
    end

    pad_state_e       state_q, state_d;
    sha_blk_t         blk_q, blk_d;
    logic [6:0]       idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             pend_q, pend_d;
    logic             first_q, first_d;

    logic             w_acc;
    logic             w_over;
    logic             w_wr;
    logic [6:0]       w_idx_nxt;
    logic [8:0]       w_bit_lo;
    sha_blk_t         w_fill;
    logic [6:0]       w_fill_idx;
    logic             w_put_len;
    logic             w_put_mark;

`ifdef SHA_PAD_LEN_CHK_EN
    localparam logic [63:0] C_MAX_LEN_BITS = MAX_MSG_BYTES << 3;

    logic err_q, err_d;

    // Once the limit is hit, length stays parked at the clamp value.
    assign w_over  = err_q | (64'(len_q) >= C_MAX_LEN_BITS);
    assign len_err = err_q;

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign w_over = 1'b0;
`endif

    assign in_rdy    = (state_q == ST_ABSORB) & ~rst_p;
    assign w_acc     = in_valid & in_rdy;
    assign w_wr      = w_acc & ~in_null & ~w_over;
    assign w_idx_nxt = w_wr ? (idx_q + 7'd1) : idx_q;
    assign w_bit_lo  = {~idx_q[5:0], 3'b000};

    assign msg_data  = blk_q;
    assign msg_valid = (state_q == ST_FULL) || (state_q == ST_EMIT_MID) ||
                       (state_q == ST_EMIT_LAST);
    assign blk_last  = (state_q == ST_EMIT_LAST);
    assign blk_first = first_q & msg_valid;

    // PADB and PADZ build a fresh block; PADZ carries only the length.
    assign w_fill_idx = ((state_q == ST_PADB) || (state_q == ST_PADZ)) ? 7'd0 : idx_q;
    assign w_put_len  = (state_q != ST_PADA);
    assign w_put_mark = (state_q != ST_PADZ);

    sha_pad_fill u_fill (
        .blk_i      (blk_q),
        .idx_i      (w_fill_idx),
        .len_i      (64'(len_q)),
        .put_len_i  (w_put_len),
        .put_mark_i (w_put_mark),
        .blk_o      (w_fill)
    );

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pend_d  = pend_q;
        first_d = first_q;
`ifdef SHA_PAD_LEN_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_ABSORB: begin
                if (w_acc) begin
                    if (w_wr) begin
                        blk_d[w_bit_lo +: 8] = in_data;
                        len_d = len_q + LEN_W'(8);
                    end
`ifdef SHA_PAD_LEN_CHK_EN
                    if (~in_null & w_over) begin
                        err_d = 1'b1;
                    end
`endif
                    idx_d = w_idx_nxt;
                    if (in_last) begin
                        if (w_idx_nxt == 7'd64) begin
                            state_d = ST_FULL;
                            pend_d  = 1'b1;
                        end else if (w_idx_nxt >= 7'(SHA_LEN_OFS)) begin
                            state_d = ST_PADA;
                        end else begin
                            state_d = ST_PAD1;
                        end
                    end else if (w_idx_nxt == 7'd64) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (msg_rdy) begin
                    idx_d   = 7'd0;
                    first_d = 1'b0;
                    pend_d  = 1'b0;
                    state_d = pend_q ? ST_PADB : ST_ABSORB;
                end
            end
            ST_PAD1: begin
                blk_d   = w_fill;
                state_d = ST_EMIT_LAST;
            end
            ST_PADA: begin
                blk_d   = w_fill;
                state_d = ST_EMIT_MID;
            end
            ST_EMIT_MID: begin
                if (msg_rdy) begin
                    idx_d   = 7'd0;
                    first_d = 1'b0;
                    state_d = ST_PADZ;
                end
            end
            ST_PADB, ST_PADZ: begin
                blk_d   = w_fill;
                state_d = ST_EMIT_LAST;
            end
            ST_EMIT_LAST: begin
                if (msg_rdy) begin
                    idx_d   = 7'd0;
                    len_d   = '0;
                    first_d = 1'b1;
`ifdef SHA_PAD_LEN_CHK_EN
                    err_d   = 1'b0;
`endif
                    state_d = ST_ABSORB;
                end
            end
            default: begin
                state_d = ST_ABSORB;
            end
        endcase
    end

    always_ff @(posedge clk_p or posedge rst_p) begin
        if (rst_p) begin
            state_q <= ST_ABSORB;
            blk_q   <= '0;
            idx_q   <= 7'd0;
            len_q   <= '0;
            pend_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pend_q  <= pend_d;
            first_q <= first_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha_msg_padder.sv
// ============================================================================
// tb_sha_msg_padder : directed table, corner sequences and random messages
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sha_msg_padder;

    logic         clk_p = 1'b0;
    logic         rst_p = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_null = 1'b0;
    logic         in_rdy;
    logic [511:0] msg_data;
    logic         msg_valid;
    logic         msg_rdy = 1'b1;
    logic         blk_first;
    logic         blk_last;
`ifdef SHA_PAD_LEN_CHK_EN
    logic         len_err;
`endif

    sha_msg_padder dut (
        .clk_p     (clk_p),
        .rst_p     (rst_p),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_null   (in_null),
        .in_rdy    (in_rdy),
        .msg_data  (msg_data),
        .msg_valid (msg_valid),
        .msg_rdy   (msg_rdy),
        .blk_first (blk_first),
        .blk_last  (blk_last)
`ifdef SHA_PAD_LEN_CHK_EN
        ,
        .len_err   (len_err)
`endif
    );

    always #5 clk_p = ~clk_p;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    typedef struct {
        int          n;
        int          start;
        int          term;       // 0 none, 1 last on data byte, 2 null terminator beat
        int          stall;
        int          exp_blocks;
        logic [63:0] exp_len;
    } vec_t;

    blk_t         exp_q[$];
    logic [7:0]   msg_q[$];
    int           checks = 0;
    int           failures = 0;
    int           rx_cnt = 0;
    logic [511:0] rx_last = '0;
    int           stall_n = 0;
    bit           rdy_rand = 1'b0;
    int           wait_cnt = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count.
    task automatic push_expected();
        logic [7:0]      p[$];
        longint unsigned bits;
        int              nb;
        blk_t            b;
        p    = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        nb = p.size() / 64;
        for (int k = 0; k < nb; k++) begin
            b.data = '0;
            for (int j = 0; j < 64; j++) b.data[511-8*j -: 8] = p[64*k+j];
            b.first = (k == 0);
            b.last  = (k == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_beat(input logic [7:0] d, input bit last, input bit nul);
        bit ok;
        int t;
        ok = 1'b0;
        t  = 0;
        in_data  = d;
        in_last  = last;
        in_null  = nul;
        in_valid = 1'b1;
        while (!ok) begin
            @(negedge clk_p);
            ok = in_rdy;
            @(posedge clk_p);
            t++;
            if (!ok && t > 3000) begin
                failures++;
                checks++;
                $display("FAIL beat_timeout: in_rdy got 0 want 1 within 3000 cycles");
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "beat acceptance timed out");
            end
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_null  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_msg(input int term, input int gap_pct, input int null_pct);
        for (int i = 0; i < msg_q.size(); i++) begin
            if (null_pct > 0 && $urandom_range(0, 99) < null_pct)
                drive_beat(8'($urandom), 1'b0, 1'b1);
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                @(posedge clk_p);
                #1;
            end
            drive_beat(msg_q[i], (term == 1) && (i == msg_q.size() - 1), 1'b0);
        end
        if (term == 2) drive_beat(8'($urandom), 1'b1, 1'b1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || msg_valid) && t < 5000) begin
            @(posedge clk_p);
            #1;
            t++;
        end
        check("drain_timeout", 512'(t >= 5000), 512'(0));
    endtask

    task automatic pulse_reset();
        #2 rst_p = 1'b1;
        @(negedge clk_p);
        check("rst_in_rdy", 512'(in_rdy), 512'(0));
        check("rst_msg_valid", 512'(msg_valid), 512'(0));
        check("rst_msg_data", msg_data, 512'(0));
        @(posedge clk_p);
        #3 rst_p = 1'b0;
    endtask

    // Block monitor, hold-stability checker and msg_rdy generator.
    initial begin
        logic hs;
        logic stalled;
        blk_t held;
        blk_t e;
        stalled = 1'b0;
        forever begin
            @(negedge clk_p);
            hs = 1'b0;
            if (!rst_p) begin
                if (stalled) begin
                    check("hold_valid", 512'(msg_valid), 512'(1));
                    check("hold_data", msg_data, held.data);
                    check("hold_first", 512'(blk_first), 512'(held.first));
                    check("hold_last", 512'(blk_last), 512'(held.last));
                end
                if (msg_valid) begin
                    check("in_rdy_busy", 512'(in_rdy), 512'(0));
                    if (msg_rdy) begin
                        hs = 1'b1;
                        rx_cnt++;
                        rx_last = msg_data;
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_block: got %h want none", msg_data);
                        end else begin
                            e = exp_q.pop_front();
                            check("blk_data", msg_data, e.data);
                            check("blk_first", 512'(blk_first), 512'(e.first));
                            check("blk_last", 512'(blk_last), 512'(e.last));
                        end
                    end
                end
                stalled    = msg_valid & ~msg_rdy;
                held.data  = msg_data;
                held.first = blk_first;
                held.last  = blk_last;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk_p);
            #1;
            if (hs || !msg_valid) wait_cnt = 0;
            if (msg_valid && wait_cnt < stall_n) begin
                msg_rdy = 1'b0;
                wait_cnt++;
            end else begin
                msg_rdy = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    initial begin
        vec_t vt[10];
        int   n;
        vt[0] = '{3,   'h61, 1, 0, 1, 64'h18};
        vt[1] = '{0,   0,    2, 0, 1, 64'h0};
        vt[2] = '{56,  0,    1, 0, 2, 64'h1C0};
        vt[3] = '{64,  0,    1, 0, 2, 64'h200};
        vt[4] = '{130, 0,    1, 5, 3, 64'h410};
        vt[5] = '{55,  7,    2, 0, 1, 64'h1B8};
        vt[6] = '{63,  9,    1, 1, 2, 64'h1F8};
        vt[7] = '{64,  3,    2, 0, 2, 64'h200};
        vt[8] = '{120, 0,    1, 2, 3, 64'h3C0};
        vt[9] = '{119, 5,    1, 0, 2, 64'h3B8};

        // Reset state
        repeat (2) @(negedge clk_p);
        check("reset_in_rdy", 512'(in_rdy), 512'(0));
        check("reset_msg_valid", 512'(msg_valid), 512'(0));
        check("reset_msg_data", msg_data, 512'(0));
        check("reset_blk_first", 512'(blk_first), 512'(0));
        check("reset_blk_last", 512'(blk_last), 512'(0));
        @(posedge clk_p);
        #3 rst_p = 1'b0;
        #1 check("post_reset_in_rdy", 512'(in_rdy), 512'(1));

        // Directed table
        for (int i = 0; i < 10; i++) begin
            msg_q.delete();
            for (int j = 0; j < vt[i].n; j++) msg_q.push_back(8'(vt[i].start + j));
            stall_n  = vt[i].stall;
            rdy_rand = 1'b0;
            rx_cnt   = 0;
            push_expected();
            send_msg(vt[i].term, 0, 0);
            wait_drain();
            check("vec_blocks", 512'(rx_cnt), 512'(vt[i].exp_blocks));
            check("vec_len_field", 512'(rx_last[63:0]), 512'(vt[i].exp_len));
            if (i == 0) check("abc_block", rx_last, {32'h61626380, 416'h0, 64'h18});
            if (i == 1) check("empty_block", rx_last, {8'h80, 504'h0});
        end

        // Reset in the middle of a message, then "abc"
        stall_n = 0;
        msg_q.delete();
        for (int j = 0; j < 20; j++) msg_q.push_back(8'($urandom));
        send_msg(0, 0, 0);
        pulse_reset();
        msg_q = '{8'h61, 8'h62, 8'h63};
        push_expected();
        send_msg(1, 0, 0);
        wait_drain();
        check("rst_msg_abc", rx_last, {32'h61626380, 416'h0, 64'h18});

        // Reset while a full block is stalled at the output
        stall_n = 1000000;
        msg_q.delete();
        for (int j = 0; j < 64; j++) msg_q.push_back(8'(j));
        send_msg(0, 0, 0);
        #2;
        check("stall_full_valid", 512'(msg_valid), 512'(1));
        pulse_reset();
        stall_n = 0;
        msg_q = '{8'h61, 8'h62, 8'h63};
        push_expected();
        send_msg(1, 0, 0);
        wait_drain();
        check("rst_emit_abc", rx_last, {32'h61626380, 416'h0, 64'h18});

        // Random messages against the reference model
        rdy_rand = 1'b1;
        for (int m = 0; m < 30; m++) begin
            msg_q.delete();
            n = $urandom_range(0, 150);
            for (int j = 0; j < n; j++) msg_q.push_back(8'($urandom));
            push_expected();
            send_msg((n == 0) ? 2 : $urandom_range(1, 2), 20, 10);
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
